nlc_ch_scheduler: RTL and testbench

Channel scheduler and configuration sequencer for the 16-channel NLC. It loads per-channel coefficient sets into the coefficient bank and arbitrates 16 per-channel ADC sample requests round-robin onto the single shared NLC datapath. It tracks in-flight samples with a tag FIFO and steers each returning result to the correct channel's x_lin output register. It sits between the channel front-ends and the NLC datapath inside NLC_wrapper.

---
 rtl/nlc_ch_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_nlc_ch_scheduler.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlc_ch_scheduler.sv
// nlc_ch_scheduler
//   Channel scheduler and configuration sequencer for the NLC.
//   - CONFIG: streams one coefficient-bank write per cfg_srdyi_port pulse,
//     channel 0..NUM_CH-1, then raises cfg_done_o.
//   - RUN: round-robin arbitration of per-channel sample requests onto the
//     shared datapath; each issued channel is pushed as a tag into an
//     in-order FIFO, and returning results are steered to that channel's
//     x_lin write strobe.
//   - DRAIN: entered when the mode leaves RUN with samples in flight; no new
//     grants, returns are still serviced until the FIFO is empty.
//
// Ports
//   clk_port, reset_port       clock / synchronous active-high reset
//   operation_mode_i_port      00 CONFIG, 01 RUN, 1x IDLE
//   cfg_srdyi_port             next coefficient set valid
//   cfg_wr_en_o/cfg_wr_addr_o  coefficient-bank write strobe / channel
//   cfg_done_o                 all channels configured
//   ch_req_i / ch_gnt_o        per-channel request level / one-hot grant pulse
//   core_srdyi_o / core_ch_o   issue strobe / issued channel to the datapath
//   core_srdyo_i               in-order datapath result valid
//   out_wr_o                   one-hot x_lin output-register write strobe
//   busy_o                     samples in flight
//   err_o                      sticky: return with nothing in flight (or watchdog)
//
// Build option
//   NLC_SCHED_WDT_EN : adds a stall watchdog (parameter WDT_LIMIT). When the
//   FIFO stays non-empty without a return for WDT_LIMIT cycles, err_o is set
//   and the FIFO is flushed.

module nlc_ch_lane (
   input  logic clk_int,
   input  logic rst,
   input  logic gnt_set,
   input  logic wr_set,
   output logic gnt,
   output logic wr
);
   // per-channel registered grant / output-write pulses
   always_ff @(posedge clk_int) begin
      if (rst) begin
         gnt <= 1'b0;
         wr  <= 1'b0;
      end else begin
         gnt <= gnt_set;
         wr  <= wr_set;
      end
   end
endmodule

module nlc_ch_scheduler #(
   parameter int NUM_CH    = 16,
   parameter int TAG_DEPTH = 8
`ifdef NLC_SCHED_WDT_EN
   , parameter int WDT_LIMIT = 64
`endif
) (
   input  logic                      clk_port,
   input  logic                      reset_port,
   input  logic [1:0]                operation_mode_i_port,
   input  logic                      cfg_srdyi_port,
   output logic                      cfg_wr_en_o,
   output logic [$clog2(NUM_CH)-1:0] cfg_wr_addr_o,
   output logic                      cfg_done_o,
   input  logic [NUM_CH-1:0]         ch_req_i,
   output logic [NUM_CH-1:0]         ch_gnt_o,
   output logic                      core_srdyi_o,
   output logic [$clog2(NUM_CH)-1:0] core_ch_o,
   input  logic                      core_srdyo_i,
   output logic [NUM_CH-1:0]         out_wr_o,
   output logic                      busy_o,
   output logic                      err_o
);
   localparam int CW = $clog2(NUM_CH);
   localparam int TW = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN, S_DRAIN} state_t;

   logic clk_int, rst;
   assign clk_int = clk_port;
   assign rst     = reset_port;

   state_t          state;
   logic [CW:0]     cfg_cnt;        // extra MSB marks "all channels written"
   logic [CW-1:0]   tag_mem [TAG_DEPTH];
   logic [TW-1:0]   wr_ptr, rd_ptr;
   logic [TW:0]     count, count_nxt;
   logic [CW-1:0]   rr_ptr, sel_ch, idx, head;
   logic            sel_found, full, empty, issue, pop, ret_err, flush;
   logic            mode_cfg, mode_run;
   logic [NUM_CH-1:0] eff_req, gnt_set, wr_set;

   assign mode_cfg = (operation_mode_i_port == 2'b00);
   assign mode_run = (operation_mode_i_port == 2'b01);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_int) begin
      if (rst) begin
         state         <= S_IDLE;
         cfg_cnt       <= '0;
         cfg_done_o    <= 1'b0;
         cfg_wr_en_o   <= 1'b0;
         cfg_wr_addr_o <= '0;
      end else begin
         cfg_wr_en_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mode_cfg) begin
                  state      <= S_CONFIG;
                  cfg_cnt    <= '0;
                  cfg_done_o <= 1'b0;
               end else if (mode_run && cfg_done_o) begin
                  state <= S_RUN;
               end
            end
            S_CONFIG: begin
               if (mode_run && cfg_done_o) begin
                  state <= S_RUN;
               end else if (operation_mode_i_port[1]) begin
                  state <= S_IDLE;
               end else if (cfg_srdyi_port && !cfg_cnt[CW]) begin
                  cfg_wr_en_o   <= 1'b1;
                  cfg_wr_addr_o <= cfg_cnt[CW-1:0];
                  cfg_cnt       <= cfg_cnt + (CW+1)'(1);
               end
               // done follows the cycle of the last bank write
               if (cfg_cnt[CW]) cfg_done_o <= 1'b1;
            end
            S_RUN: begin
               if (!mode_run) begin
                  if (!empty) begin
                     state <= S_DRAIN;
                  end else if (mode_cfg) begin
                     state      <= S_CONFIG;
                     cfg_cnt    <= '0;
                     cfg_done_o <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  if (mode_cfg) begin
                     state      <= S_CONFIG;
                     cfg_cnt    <= '0;
                     cfg_done_o <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------- arbitration
   // A channel being granted this cycle still shows its request; mask it so
   // the same request is not granted twice.
   assign eff_req = ch_req_i & ~ch_gnt_o;

   // first requester at or after rr_ptr; index arithmetic wraps mod NUM_CH
   always_comb begin
      sel_found = 1'b0;
      sel_ch    = '0;
      idx       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = rr_ptr + CW'(i);
         if (!sel_found && eff_req[idx]) begin
            sel_found = 1'b1;
            sel_ch    = idx;
         end
      end
   end

   // full is derived from the registered count, so a pop on a full FIFO
   // cannot admit a push in the same cycle
   assign full    = (count == (TW+1)'(TAG_DEPTH));
   assign empty   = (count == '0);
   assign issue   = (state == S_RUN) && mode_run && sel_found && !full && !flush;
   assign pop     = core_srdyo_i && !empty;
   assign ret_err = core_srdyo_i && empty;
   assign head    = tag_mem[rd_ptr];

   assign count_nxt = count + (TW+1)'(issue) - (TW+1)'(pop);

   // ------------------------------------------------------------- tag FIFO
   always_ff @(posedge clk_int) begin
      if (issue) tag_mem[wr_ptr] <= sel_ch;
   end

   always_ff @(posedge clk_int) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         busy_o       <= 1'b0;
         rr_ptr       <= '0;
         core_srdyi_o <= 1'b0;
         core_ch_o    <= '0;
         err_o        <= 1'b0;
      end else begin
         core_srdyi_o <= issue;
         core_ch_o    <= issue ? sel_ch : '0;
         if (issue) begin
            wr_ptr <= wr_ptr + TW'(1);
            rr_ptr <= sel_ch + CW'(1);
         end
         if (ret_err || flush) err_o <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy_o <= 1'b0;
         end else begin
            if (pop) rd_ptr <= rd_ptr + TW'(1);
            count  <= count_nxt;
            busy_o <= (count_nxt != '0);
         end
      end
   end

   // ------------------------------------------------------------- watchdog
`ifdef NLC_SCHED_WDT_EN
   localparam int WW = $clog2(WDT_LIMIT + 1);
   logic [WW-1:0] wdt_cnt;
   logic          wdt_inc;

   assign wdt_inc = !empty && !core_srdyo_i;
   assign flush   = wdt_inc && (wdt_cnt == WW'(WDT_LIMIT - 1));

   always_ff @(posedge clk_int) begin
      if (rst || flush || !wdt_inc) wdt_cnt <= '0;
      else                          wdt_cnt <= wdt_cnt + WW'(1);
   end
`else
   assign flush = 1'b0;
`endif

   // ---------------------------------------------------------- lane strobes
   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      assign gnt_set[k] = issue && (sel_ch == CW'(k));
      assign wr_set[k]  = pop && !flush && (head == CW'(k));
      nlc_ch_lane u_lane (
         .clk_int (clk_int),
         .rst     (rst),
         .gnt_set (gnt_set[k]),
         .wr_set  (wr_set[k]),
         .gnt     (ch_gnt_o[k]),
         .wr      (out_wr_o[k])
      );
   end

endmodule

// File: tb/tb_nlc_ch_scheduler.sv
module tb_nlc_ch_scheduler;
   logic        clk_port = 1'b0;
   logic        reset_port = 1'b1;
   logic [1:0]  operation_mode_i_port = 2'b10;
   logic        cfg_srdyi_port = 1'b0;
   logic        cfg_wr_en_o;
   logic [3:0]  cfg_wr_addr_o;
   logic        cfg_done_o;
   logic [15:0] ch_req_i = '0;
   logic [15:0] ch_gnt_o;
   logic        core_srdyi_o;
   logic [3:0]  core_ch_o;
   logic        core_srdyo_i = 1'b0;
   logic [15:0] out_wr_o;
   logic        busy_o;
   logic        err_o;

   nlc_ch_scheduler dut (
      .clk_port              (clk_port),
      .reset_port            (reset_port),
      .operation_mode_i_port (operation_mode_i_port),
      .cfg_srdyi_port        (cfg_srdyi_port),
      .cfg_wr_en_o           (cfg_wr_en_o),
      .cfg_wr_addr_o         (cfg_wr_addr_o),
      .cfg_done_o            (cfg_done_o),
      .ch_req_i              (ch_req_i),
      .ch_gnt_o              (ch_gnt_o),
      .core_srdyi_o          (core_srdyi_o),
      .core_ch_o             (core_ch_o),
      .core_srdyo_i          (core_srdyo_i),
      .out_wr_o              (out_wr_o),
      .busy_o                (busy_o),
      .err_o                 (err_o)
   );

   always #5 clk_port = ~clk_port;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int exp_q[$];       // expected grant / cfg address order
   int ret_q[$];       // expected out_wr channel order
   int ret_cyc_q[$];   // expected out_wr cycle
   logic       dp_auto = 1'b0;
   logic [4:0] dp_pipe = '0;

   // advance one clock; outputs are sampled 1 time unit after the edge.
   // With dp_auto set, the datapath answers 4 cycles after each issue.
   task automatic tick();
      @(posedge clk_port);
      #1;
      cyc++;
      dp_pipe = {dp_pipe[3:0], core_srdyi_o & dp_auto};
      if (dp_auto) core_srdyo_i = dp_pipe[4];
   endtask

   function automatic logic [15:0] oh(input int k);
      logic [15:0] v;
      v = 16'd1 << k;
      return v;
   endfunction

   task automatic test_reset();
      reset_port = 1'b1;
      tick();
      tick();
      vectors++;
      if ({cfg_wr_en_o, cfg_wr_addr_o, cfg_done_o} !== 6'd0) begin
         miscompares++;
         $display("FAIL reset_cfg: got %b expected 0", {cfg_wr_en_o, cfg_wr_addr_o, cfg_done_o});
      end
      vectors++;
      if ({ch_gnt_o, core_srdyi_o, core_ch_o} !== 21'd0) begin
         miscompares++;
         $display("FAIL reset_issue: got %h expected 0", {ch_gnt_o, core_srdyi_o, core_ch_o});
      end
      vectors++;
      if ({out_wr_o, busy_o, err_o} !== 18'd0) begin
         miscompares++;
         $display("FAIL reset_ret: got %h expected 0", {out_wr_o, busy_o, err_o});
      end
      reset_port = 1'b0;
      tick();
   endtask

   task automatic test_run_gating();
      operation_mode_i_port = 2'b01;
      ch_req_i = 16'hFFFF;
      for (int c = 0; c < 6; c++) begin
         tick();
         vectors++;
         if (ch_gnt_o !== 16'd0 || core_srdyi_o !== 1'b0) begin
            miscompares++;
            $display("FAIL gating_no_grant: got gnt %h srdy %b expected 0", ch_gnt_o, core_srdyi_o);
         end
      end
      ch_req_i = '0;
      operation_mode_i_port = 2'b10;
      tick();
   endtask

   task automatic test_config();
      int nstb, e;
      operation_mode_i_port = 2'b00;
      tick();
      nstb = 0;
      exp_q = {};
      for (int i = 0; i < 17; i++) begin
         cfg_srdyi_port = 1'b1;
         if (i < 16) exp_q.push_back(i);
         tick();
         if (cfg_wr_en_o) begin
            nstb++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL cfg_extra_strobe: got strobe addr %0d expected none", cfg_wr_addr_o);
            end else begin
               e = exp_q.pop_front();
               if (cfg_wr_addr_o !== 4'(e)) begin
                  miscompares++;
                  $display("FAIL cfg_addr: got %0d expected %0d", cfg_wr_addr_o, e);
               end
            end
         end
         vectors++;
         if (cfg_done_o !== (i == 16)) begin
            miscompares++;
            $display("FAIL cfg_done_step%0d: got %b expected %b", i, cfg_done_o, (i == 16));
         end
      end
      cfg_srdyi_port = 1'b0;
      tick();
      vectors++;
      if (nstb != 16 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL cfg_strobe_count: got %0d expected 16", nstb);
      end
      vectors++;
      if (cfg_done_o !== 1'b1 || cfg_wr_en_o !== 1'b0) begin
         miscompares++;
         $display("FAIL cfg_final: got done %b en %b expected done 1 en 0", cfg_done_o, cfg_wr_en_o);
      end
   endtask

   task automatic test_round_robin();
      int ngnt, first, e, ec;
      exp_q = {};
      for (int i = 0; i < 17; i++) exp_q.push_back(i % 16);
      ret_q = {};
      ret_cyc_q = {};
      ngnt = 0;
      first = 0;
      operation_mode_i_port = 2'b01;
      ch_req_i = 16'hFFFF;
      dp_auto = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (ch_gnt_o != 16'd0) begin
            if (ngnt == 0) first = cyc;
            ngnt++;
            if (ngnt == 17) ch_req_i = '0;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL rr_extra_grant: got %h expected none", ch_gnt_o);
            end else begin
               e = exp_q.pop_front();
               if (ch_gnt_o !== oh(e) || core_srdyi_o !== 1'b1 || core_ch_o !== 4'(e)) begin
                  miscompares++;
                  $display("FAIL rr_grant: got gnt %h ch %0d srdy %b expected gnt %h ch %0d",
                           ch_gnt_o, core_ch_o, core_srdyi_o, oh(e), e);
               end
               vectors++;
               if (cyc != first + ngnt - 1) begin
                  miscompares++;
                  $display("FAIL rr_throughput: got cycle %0d expected %0d", cyc, first + ngnt - 1);
               end
               ret_q.push_back(e);
               ret_cyc_q.push_back(cyc + 5);
            end
         end
         if (out_wr_o != 16'd0) begin
            vectors++;
            if (ret_q.size() == 0) begin
               miscompares++;
               $display("FAIL rr_extra_out_wr: got %h expected none", out_wr_o);
            end else begin
               e  = ret_q.pop_front();
               ec = ret_cyc_q.pop_front();
               if (out_wr_o !== oh(e) || cyc != ec) begin
                  miscompares++;
                  $display("FAIL rr_out_wr: got %h at cycle %0d expected %h at cycle %0d",
                           out_wr_o, cyc, oh(e), ec);
               end
            end
         end
         if (ngnt >= 17 && ret_q.size() == 0) break;
      end
      vectors++;
      if (ngnt != 17 || ret_q.size() != 0) begin
         miscompares++;
         $display("FAIL rr_timeout: got %0d grants %0d pending expected 17 grants 0 pending",
                  ngnt, ret_q.size());
      end
      dp_auto = 1'b0;
      core_srdyo_i = 1'b0;
      dp_pipe = '0;
   endtask

   task automatic test_backpressure();
      int ngnt, e;
      exp_q = {};
      for (int i = 1; i <= 8; i++) exp_q.push_back(i);
      ret_q = {};
      ngnt = 0;
      ch_req_i = 16'hFFFF;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (ch_gnt_o != 16'd0) begin
            ngnt++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL bp_extra_grant: got %h expected none", ch_gnt_o);
            end else begin
               e = exp_q.pop_front();
               if (ch_gnt_o !== oh(e)) begin
                  miscompares++;
                  $display("FAIL bp_grant: got %h expected %h", ch_gnt_o, oh(e));
               end
               ret_q.push_back(e);
            end
         end
      end
      vectors++;
      if (ngnt != 8 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_full: got %0d grants busy %b expected 8 grants busy 1", ngnt, busy_o);
      end
      // one return frees one slot, usable only from the following cycle
      core_srdyo_i = 1'b1;
      tick();
      core_srdyo_i = 1'b0;
      e = ret_q.pop_front();
      vectors++;
      if (out_wr_o !== oh(e) || ch_gnt_o !== 16'd0) begin
         miscompares++;
         $display("FAIL bp_pop: got out_wr %h gnt %h expected out_wr %h gnt 0", out_wr_o, ch_gnt_o, oh(e));
      end
      tick();
      vectors++;
      if (ch_gnt_o !== oh(9)) begin
         miscompares++;
         $display("FAIL bp_regrant: got %h expected %h", ch_gnt_o, oh(9));
      end
      ret_q.push_back(9);
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (ch_gnt_o !== 16'd0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: got gnt %h busy %b expected gnt 0 busy 1", ch_gnt_o, busy_o);
         end
      end
      // bring occupancy down to 3 for the drain scenario
      ch_req_i = '0;
      for (int i = 0; i < 5; i++) begin
         core_srdyo_i = 1'b1;
         tick();
         e = ret_q.pop_front();
         vectors++;
         if (out_wr_o !== oh(e)) begin
            miscompares++;
            $display("FAIL bp_return: got %h expected %h", out_wr_o, oh(e));
         end
      end
      core_srdyo_i = 1'b0;
   endtask

   task automatic test_drain();
      int e;
      operation_mode_i_port = 2'b00;
      ch_req_i = 16'hFFFF;
      tick();
      vectors++;
      if (ch_gnt_o !== 16'd0 || cfg_done_o !== 1'b1 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_enter: got gnt %h done %b busy %b expected gnt 0 done 1 busy 1",
                  ch_gnt_o, cfg_done_o, busy_o);
      end
      for (int i = 0; i < 3; i++) begin
         core_srdyo_i = 1'b1;
         tick();
         core_srdyo_i = 1'b0;
         e = ret_q.pop_front();
         vectors++;
         if (out_wr_o !== oh(e) || ch_gnt_o !== 16'd0) begin
            miscompares++;
            $display("FAIL drain_return: got out_wr %h gnt %h expected out_wr %h gnt 0",
                     out_wr_o, ch_gnt_o, oh(e));
         end
         tick();
         if (i < 2) begin
            vectors++;
            if (cfg_done_o !== 1'b1 || ch_gnt_o !== 16'd0) begin
               miscompares++;
               $display("FAIL drain_hold: got done %b gnt %h expected done 1 gnt 0", cfg_done_o, ch_gnt_o);
            end
         end
      end
      tick();
      vectors++;
      if (cfg_done_o !== 1'b0 || busy_o !== 1'b0 || ch_gnt_o !== 16'd0) begin
         miscompares++;
         $display("FAIL drain_exit: got done %b busy %b gnt %h expected 0 0 0", cfg_done_o, busy_o, ch_gnt_o);
      end
      ch_req_i = '0;
      cfg_srdyi_port = 1'b1;
      tick();
      cfg_srdyi_port = 1'b0;
      vectors++;
      if (cfg_wr_en_o !== 1'b1 || cfg_wr_addr_o !== 4'd0) begin
         miscompares++;
         $display("FAIL drain_config: got en %b addr %0d expected en 1 addr 0", cfg_wr_en_o, cfg_wr_addr_o);
      end
   endtask

   task automatic test_error();
      vectors++;
      if (err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL err_pre: got %b expected 0", err_o);
      end
      core_srdyo_i = 1'b1;
      tick();
      core_srdyo_i = 1'b0;
      vectors++;
      if (err_o !== 1'b1 || out_wr_o !== 16'd0 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL err_empty_return: got err %b out_wr %h busy %b expected 1 0 0", err_o, out_wr_o, busy_o);
      end
      tick();
      tick();
      vectors++;
      if (err_o !== 1'b1) begin
         miscompares++;
         $display("FAIL err_sticky: got %b expected 1", err_o);
      end
      reset_port = 1'b1;
      tick();
      reset_port = 1'b0;
      operation_mode_i_port = 2'b10;
      tick();
      vectors++;
      if (err_o !== 1'b0 || cfg_done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL err_reset: got err %b done %b expected 0 0", err_o, cfg_done_o);
      end
   endtask

`ifdef NLC_SCHED_WDT_EN
   task automatic test_wdt();
      int got;
      test_config();
      operation_mode_i_port = 2'b01;
      ch_req_i = 16'h0004;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         tick();
         if (ch_gnt_o != 16'd0) begin
            got = 1;
            ch_req_i = '0;
         end
      end
      vectors++;
      if (got == 0) begin
         miscompares++;
         $display("FAIL wdt_grant: got none expected %h", oh(2));
      end
      for (int c = 0; c < 30; c++) tick();
      vectors++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL wdt_early: got err %b busy %b expected 0 1", err_o, busy_o);
      end
      for (int c = 0; c < 40; c++) tick();
      vectors++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL wdt_fire: got err %b busy %b expected 1 0", err_o, busy_o);
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_run_gating();
      test_config();
      test_round_robin();
      test_backpressure();
      test_drain();
      test_error();
`ifdef NLC_SCHED_WDT_EN
      test_wdt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
